// File: rtl/irrigation_countdown_bcd_pkg.sv
// Shared definitions for the irrigation countdown timer: FSM encoding, BCD limits,
// and the preset-digit clamp used at load time.
package irrigation_pkg;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         PRESET_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } fsm_t;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction
endpackage

// File: rtl/irrigation_countdown_bcd_if.sv
// Control/status bundle of the countdown timer; master drives commands, slave is the timer.
interface irrigation_countdown_bcd_if #(parameter int N_DIGITS = 2);
  logic                  tick;
  logic [1:0]            state;
  logic [1:0]            irrigation_type;
  logic                  transition;
  logic                  load;
  logic                  pause;
  logic [4*N_DIGITS-1:0] digits;
  logic                  busy;
  logic                  expired;
  logic                  done;

  modport master (output tick, state, irrigation_type, transition, load, pause,
                  input  digits, busy, expired, done);
  modport slave  (input  tick, state, irrigation_type, transition, load, pause,
                  output digits, busy, expired, done);
endinterface

// File: rtl/irrigation_countdown_bcd_digit.sv
// One BCD digit of the down-counter; load wins over decrement, 0 borrows to 9.
module bcd_down_digit
  import irrigation_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_en,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       is_zero
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          digit <= 4'd0;
    else if (load_en) digit <= load_val;
    else if (dec_en)  digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
  end

  assign is_zero = (digit == 4'd0);
endmodule

// File: rtl/irrigation_countdown_bcd.sv
// BCD countdown timer: preset select + clamp, IDLE/RUN/PAUSED FSM, registered done pulse,
// and a borrow-chained array of digit counters. Single clock, tick used only as an enable.
module irrigation_countdown_bcd
  import irrigation_pkg::*;
#(
  parameter int                       N_DIGITS     = 2,
  parameter logic [16*4*N_DIGITS-1:0] PRESET_TABLE = '0,
  parameter logic [4*N_DIGITS-1:0]    TRANS_PRESET = 'h05
) (
  input  logic                          clk,
  input  logic                          rst,
  irrigation_countdown_bcd_if.slave     bus
);
  localparam int W = 4*N_DIGITS;

  logic [PRESET_IDX_W-1:0] idx;
  logic [W-1:0]            preset_raw, preset_c, cnt;
  logic [N_DIGITS-1:0]     is_zero;
  logic [N_DIGITS:0]       borrow;
  logic                    dec, one_left, preset_zero, done_q;
  fsm_t                    fsm;

  assign idx        = {bus.state, bus.irrigation_type};
  assign preset_raw = bus.transition ? TRANS_PRESET : PRESET_TABLE[int'(idx)*W +: W];
  assign preset_zero = (preset_c == '0);

  // Decrement only in RUN with no higher-priority command this cycle.
  assign dec       = (fsm == ST_RUN) && bus.tick && !bus.pause && !bus.load;
  assign borrow[0] = dec;
  assign one_left  = (cnt == W'(1));

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    assign preset_c[k*4 +: 4] = bcd_clamp(preset_raw[k*4 +: 4]);
    assign borrow[k+1]        = borrow[k] & is_zero[k];

    bcd_down_digit u_dig (
      .clk      (clk),
      .rst      (rst),
      .dec_en   (borrow[k]),
      .load_en  (bus.load),
      .load_val (preset_c[k*4 +: 4]),
      .digit    (cnt[k*4 +: 4]),
      .is_zero  (is_zero[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        fsm <= preset_zero ? ST_IDLE : (bus.pause ? ST_PAUSED : ST_RUN);
      end else begin
        case (fsm)
          ST_RUN: begin
            if (bus.pause) fsm <= ST_PAUSED;
            else if (bus.tick && one_left) begin
              fsm    <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
          ST_PAUSED: if (!bus.pause) fsm <= ST_RUN;
          default:   fsm <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.digits  = cnt;
  assign bus.busy    = (fsm != ST_IDLE);
  assign bus.expired = &is_zero;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_irrigation_countdown_bcd.sv
// Randomized + directed bench; reference model keeps the count as a plain integer.
module tb_irrigation_countdown_bcd;
  localparam int N_DIGITS = 2;
  localparam int W = 4*N_DIGITS;
  localparam logic [16*W-1:0] TABLE = {
    8'h15, 8'h02, 8'hF3, 8'h08, 8'h40, 8'h99, 8'h00, 8'h5A,
    8'h01, 8'h12, 8'hAF, 8'h10, 8'h03, 8'h20, 8'h37, 8'h00};
  localparam logic [W-1:0] TRANS = 8'h05;

  logic clk = 0, rst = 1;
  irrigation_countdown_bcd_if #(.N_DIGITS(N_DIGITS)) bus ();

  irrigation_countdown_bcd #(.N_DIGITS(N_DIGITS), .PRESET_TABLE(TABLE), .TRANS_PRESET(TRANS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_cnt = 0;   // model count as a decimal integer
  int m_mode = 0;  // 0 idle, 1 running, 2 paused
  bit m_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int preset_val(input logic [3:0] i, input bit tr);
    logic [W-1:0] raw;
    int v = 0, pw = 1, nib;
    raw = tr ? TRANS : TABLE[int'(i)*W +: W];
    for (int k = 0; k < N_DIGITS; k++) begin
      nib = int'(raw[k*4 +: 4]);
      if (nib > 9) nib = 9;
      v += nib * pw;
      pw *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".digits"},  32'(bus.digits),  32'(to_bcd(m_cnt)));
    chk({tag, ".busy"},    32'(bus.busy),    32'(m_mode != 0));
    chk({tag, ".expired"}, 32'(bus.expired), 32'(m_cnt == 0));
    chk({tag, ".done"},    32'(bus.done),    32'(m_done));
  endtask

  // Apply one cycle of inputs, advance the model, check just after the edge.
  task automatic step(input bit ld, tk, ps, tr, input logic [1:0] st, ty, input string tag);
    int v;
    bus.load = ld; bus.tick = tk; bus.pause = ps; bus.transition = tr;
    bus.state = st; bus.irrigation_type = ty;
    @(posedge clk);
    m_done = 0;
    if (ld) begin
      v = preset_val({st, ty}, tr);
      m_cnt = v;
      m_mode = (v == 0) ? 0 : (ps ? 2 : 1);
    end else if (m_mode == 1) begin
      if (ps) m_mode = 2;
      else if (tk) begin
        m_cnt--;
        if (m_cnt == 0) begin m_mode = 0; m_done = 1; end
      end
    end else if (m_mode == 2) begin
      if (!ps) m_mode = 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_load(input logic [3:0] i, input bit tr, tk, input string tag);
    step(1, tk, 0, tr, i[3:2], i[1:0], tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      step(0, 1, 0, 0, 2'd0, 2'd0, tag);
      step(0, 0, 0, 0, 2'd0, 2'd0, tag);
    end
  endtask

  int done_cnt;

  initial begin
    bus.tick = 0; bus.load = 0; bus.pause = 0; bus.transition = 0;
    bus.state = 0; bus.irrigation_type = 0;
    #12;
    check_all("reset");
    #4 rst = 0;
    @(posedge clk); #1;
    step(0, 1, 0, 0, 2'd0, 2'd0, "idle_tick");

    // Async reset in the middle of a run at 37.
    do_load(4'd1, 0, 0, "ld37");
    chk("ld37.val", 32'(bus.digits), 32'h37);
    #2 rst = 1;
    #1;
    m_cnt = 0; m_mode = 0; m_done = 0;
    check_all("async_rst");
    #2 rst = 0;
    step(0, 0, 0, 0, 2'd0, 2'd0, "post_rst");

    // Entry {01,10} = 12; full countdown with a single done pulse.
    do_load(4'b0110, 0, 0, "ld12");
    chk("ld12.val", 32'(bus.digits), 32'h12);
    done_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      step(0, 1, 0, 0, 2'd0, 2'd0, "cd12");
      done_cnt += int'(bus.done);
    end
    chk("cd12.zero", 32'(bus.digits), 32'h00);
    step(0, 1, 0, 0, 2'd0, 2'd0, "cd12.after");
    done_cnt += int'(bus.done);
    chk("cd12.done_cnt", 32'(done_cnt), 32'd1);

    // Transition preset overrides the table.
    do_load(4'b1011, 1, 0, "ldtr");
    chk("ldtr.val", 32'(bus.digits), 32'h05);
    ticks(5, "cdtr");

    // Pause at 20: hold through ticks, then one tick gives 19.
    do_load(4'd2, 0, 0, "ld20");
    for (int j = 0; j < 4; j++) step(0, 1, 1, 0, 2'd0, 2'd0, "pause");
    chk("pause.hold", 32'(bus.digits), 32'h20);
    step(0, 0, 0, 0, 2'd0, 2'd0, "unpause");
    step(0, 1, 0, 0, 2'd0, 2'd0, "tick19");
    chk("tick19.val", 32'(bus.digits), 32'h19);

    // Load with a coincident tick: full duration.
    do_load(4'd3, 0, 1, "ld03tk");
    chk("ld03tk.val", 32'(bus.digits), 32'h03);
    ticks(3, "cd03");

    // Zero preset, clamp cases, reload while running.
    do_load(4'd0, 0, 0, "ld00");
    ticks(2, "idle00");
    do_load(4'd5, 0, 0, "ldAF");
    chk("ldAF.val", 32'(bus.digits), 32'h99);
    ticks(2, "cd99");
    do_load(4'd13, 0, 0, "ldF3");
    chk("ldF3.val", 32'(bus.digits), 32'h93);
    do_load(4'd8, 0, 0, "reload");
    ticks(3, "cd59");

    // Random traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
